// File: rtl/modport_slave_mem_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : modport_slave_mem_if                                       |
// | Purpose : Bus bundle for the register-file slave (master/slave view) |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface modport_slave_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              write;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_out;

    modport master (
        output write,
        output data_in,
        output address,
        input  data_out
    );

    modport slave (
        input  write,
        input  data_in,
        input  address,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/modport_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : modport_slave_mem                                          |
// | Purpose : 256x16 resettable flop register file, write-through slave  |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module modport_slave_mem #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    modport_slave_mem_if.slave   bus
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_data_out;

    // Every word lives in a flop so reset can clear the whole array at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_data_out <= '0;
        end else if (bus.write) begin
            r_mem[bus.address] <= bus.data_in;
            r_data_out         <= bus.data_in;
        end else begin
            r_data_out <= r_mem[bus.address];
        end
    end

    assign bus.data_out = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_modport_slave_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_modport_slave_mem                                       |
// | Purpose : Directed + random self-checking bench for the slave memory |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_modport_slave_mem;

    logic clk;
    logic rst_n;

    modport_slave_mem_if #(.DATA_W(16), .ADDR_W(8)) bus_if ();

    modport_slave_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] ref_mem [256];
    logic [15:0] exp_q;
    int          checks;
    int          errors;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
        exp_q = 16'h0000;
    endtask

    // One bus transaction: drive on the falling edge, check 1 ns after the rising edge.
    task automatic xfer(input logic w, input logic [7:0] a, input logic [15:0] d, input string tag);
        @(negedge clk);
        bus_if.write   = w;
        bus_if.address = a;
        bus_if.data_in = d;
        @(posedge clk);
        if (w) begin
            ref_mem[a] = d;
            exp_q      = d;
        end else begin
            exp_q = ref_mem[a];
        end
        #1 check(tag, bus_if.data_out, exp_q);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [15:0] rd;
        logic        rw;
        checks = 0;
        errors = 0;
        model_reset();
        rst_n          = 1'b0;
        bus_if.write   = 1'b0;
        bus_if.address = 8'h00;
        bus_if.data_in = 16'h0000;

        // Reset for two cycles, then read 0x00/0x7F/0xFF
        repeat (2) @(posedge clk);
        #1 check("reset_dout", bus_if.data_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1'b0, 8'h00, 16'h0000, "reset_rd_00");
        xfer(1'b0, 8'h7F, 16'h0000, "reset_rd_7F");
        xfer(1'b0, 8'hFF, 16'h0000, "reset_rd_FF");

        // Write / readback, including write-through
        xfer(1'b1, 8'h10, 16'hA5A5, "wr_thru_10");
        xfer(1'b1, 8'hFF, 16'h1234, "wr_thru_FF");
        xfer(1'b0, 8'h10, 16'h0000, "rd_10");
        xfer(1'b0, 8'hFF, 16'h0000, "rd_FF");
        check("rd_FF_const", bus_if.data_out, 16'h1234);

        // Isolation
        xfer(1'b1, 8'h20, 16'hFFFF, "iso_wr_20");
        xfer(1'b0, 8'h1F, 16'h0000, "iso_rd_1F");
        check("iso_1F_const", bus_if.data_out, 16'h0000);
        xfer(1'b0, 8'h21, 16'h0000, "iso_rd_21");
        check("iso_21_const", bus_if.data_out, 16'h0000);
        xfer(1'b1, 8'h20, 16'h0001, "iso_ovr_20");
        xfer(1'b0, 8'h20, 16'h0000, "iso_rd_20");
        check("iso_20_const", bus_if.data_out, 16'h0001);

        // Back-to-back full sweep
        for (int a = 0; a < 256; a++) begin
            ra = a[7:0];
            xfer(1'b1, ra, {ra, ~ra}, "b2b_wr");
        end
        for (int a = 0; a < 256; a++) begin
            ra = a[7:0];
            xfer(1'b0, ra, 16'h0000, "b2b_rd");
            check("b2b_pattern", bus_if.data_out, {ra, ~ra});
        end

        // Random mix against the reference array
        for (int n = 0; n < 400; n++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 8'($urandom_range(0, 255));
            rd = 16'($urandom);
            xfer(rw, ra, rd, "rand");
        end

        // Reset mid-operation overrides a pending write
        xfer(1'b1, 8'h05, 16'hBEEF, "mid_wr_05");
        @(negedge clk);
        bus_if.write   = 1'b1;
        bus_if.address = 8'h06;
        bus_if.data_in = 16'hCAFE;
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("mid_rst_immediate", bus_if.data_out, 16'h0000);
        @(posedge clk);
        #1 check("mid_rst_held", bus_if.data_out, 16'h0000);
        @(negedge clk);
        bus_if.write = 1'b0;
        rst_n        = 1'b1;
        xfer(1'b0, 8'h05, 16'h0000, "mid_rd_05");
        xfer(1'b0, 8'h06, 16'h0000, "mid_rd_06");
        check("mid_06_const", bus_if.data_out, 16'h0000);

        // Hold: data_out stable across and between edges
        xfer(1'b1, 8'h10, 16'h00AA, "hold_wr");
        xfer(1'b0, 8'h10, 16'h0000, "hold_rd");
        for (int k = 0; k < 5; k++) begin
            #3 check("hold_mid", bus_if.data_out, 16'h00AA);
            @(posedge clk);
            #1 check("hold_edge", bus_if.data_out, 16'h00AA);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
